// File: rtl/nibble_pack_unit.sv
`default_nettype none
// ============================================================================
//  Module   : nibble_pack_unit
//  Purpose  : Packs a stream of 4-bit nibbles (up to 8 per packet, early
//             terminate with in_last) into a 16-bit operand pair rs/rt,
//             held in a single-entry valid/ready output buffer.
//             Optional feature macro: PACK_SUM_EN (adds out_sum, the
//             unsigned sum of the packed nibbles).
//  Revision : 1.0  initial release
// ============================================================================
module nibble_pack_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  in_nibble,
  input  logic        in_last,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_rs,
  output logic [15:0] out_rt,
  output logic [15:0] out_sum
);

  localparam logic [2:0] c_last_idx = 3'd7;

  // Packet position counter and assembly registers
  logic [2:0]  cnt_q, cnt_d;
  logic [15:0] asm_rs_q, asm_rs_d;
  logic [15:0] asm_rt_q, asm_rt_d;

  // Single-entry output buffer
  logic        out_valid_q, out_valid_d;
  logic [15:0] out_rs_q, out_rs_d;
  logic [15:0] out_rt_q, out_rt_d;

  logic        w_accept;
  logic        w_complete;
  logic [15:0] w_ins;
  logic [15:0] w_rs_full;
  logic [15:0] w_rt_full;

  // Handshake: input only stalls while a finished packet is held unaccepted
  always_comb begin
    in_ready   = ~out_valid_q | out_ready;
    w_accept   = in_valid & in_ready;
    w_complete = w_accept & (in_last | (cnt_q == c_last_idx));
  end

  // Place the incoming nibble at its slot; index 0 of each word is the MS nibble
  always_comb begin
    w_ins     = {12'h000, in_nibble} << {~cnt_q[1:0], 2'b00};
    w_rs_full = cnt_q[2] ? asm_rs_q : (asm_rs_q | w_ins);
    w_rt_full = cnt_q[2] ? (asm_rt_q | w_ins) : asm_rt_q;
  end

  // Next state for counter, assembly registers and output buffer
  always_comb begin
    cnt_d       = cnt_q;
    asm_rs_d    = asm_rs_q;
    asm_rt_d    = asm_rt_q;
    out_valid_d = out_valid_q;
    out_rs_d    = out_rs_q;
    out_rt_d    = out_rt_q;
    if (w_complete) begin
      // Completion wins over a same-cycle drain: the buffer is reloaded
      cnt_d       = 3'd0;
      asm_rs_d    = 16'h0000;
      asm_rt_d    = 16'h0000;
      out_valid_d = 1'b1;
      out_rs_d    = w_rs_full;
      out_rt_d    = w_rt_full;
    end else begin
      if (w_accept) begin
        cnt_d    = cnt_q + 3'd1;
        asm_rs_d = w_rs_full;
        asm_rt_d = w_rt_full;
      end
      if (out_ready) begin
        out_valid_d = 1'b0;
      end
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q       <= 3'd0;
      asm_rs_q    <= 16'h0000;
      asm_rt_q    <= 16'h0000;
      out_valid_q <= 1'b0;
      out_rs_q    <= 16'h0000;
      out_rt_q    <= 16'h0000;
    end else begin
      cnt_q       <= cnt_d;
      asm_rs_q    <= asm_rs_d;
      asm_rt_q    <= asm_rt_d;
      out_valid_q <= out_valid_d;
      out_rs_q    <= out_rs_d;
      out_rt_q    <= out_rt_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_rs    = out_rs_q;
  assign out_rt    = out_rt_q;

`ifdef PACK_SUM_EN
  // Running nibble sum; 7 bits covers the maximum of 8 * 15 = 120
  logic [6:0] sum_q, sum_d;
  logic [6:0] out_sum_q, out_sum_d;
  logic [6:0] w_sum_full;

  // Accumulate accepted nibbles, hand the total to the output on completion
  always_comb begin
    w_sum_full = sum_q + {3'b000, in_nibble};
    sum_d      = sum_q;
    out_sum_d  = out_sum_q;
    if (w_complete) begin
      sum_d     = 7'd0;
      out_sum_d = w_sum_full;
    end else if (w_accept) begin
      sum_d = w_sum_full;
    end
  end

  // Sum registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      sum_q     <= 7'd0;
      out_sum_q <= 7'd0;
    end else begin
      sum_q     <= sum_d;
      out_sum_q <= out_sum_d;
    end
  end

  assign out_sum = {9'b0, out_sum_q};
`else
  assign out_sum = 16'h0000;
`endif

endmodule
`default_nettype wire

// File: tb/tb_nibble_pack_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_nibble_pack_unit
//  Purpose  : Self-checking bench for nibble_pack_unit: directed scenarios
//             with literal expectations plus randomized traffic compared
//             every cycle against a packet-level reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_nibble_pack_unit;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_nibble;
  logic        in_last;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_rs;
  logic [15:0] out_rt;
  logic [15:0] out_sum;

  int n_vec;
  int n_err;
  bit chk_en;

  // Reference model state: nibbles collected so far, and the held packet
  int          m_nibs[8];
  int          m_cnt;
  bit          m_valid;
  logic [15:0] m_rs, m_rt, m_sum;

  nibble_pack_unit dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_nibble (in_nibble),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_rs    (out_rs),
    .out_rt    (out_rt),
    .out_sum   (out_sum)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [15:0] sum_exp(input logic [15:0] v);
`ifdef PACK_SUM_EN
    return v;
`else
    return 16'h0000;
`endif
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Packet-level model: collect nibbles, build words arithmetically on completion
  task automatic model_edge();
    bit acc, done;
    int rs, rt, s;
    if (rst) begin
      m_cnt = 0; m_valid = 0; m_rs = 0; m_rt = 0; m_sum = 0;
    end else begin
      acc  = in_valid && (!m_valid || out_ready);
      done = 0;
      if (acc) begin
        m_nibs[m_cnt] = int'(in_nibble);
        m_cnt++;
        if (in_last || m_cnt == 8) begin
          rs = 0; rt = 0; s = 0;
          for (int i = 0; i < m_cnt; i++) begin
            if (i < 4) rs += m_nibs[i] * (1 << (4 * (3 - i)));
            else       rt += m_nibs[i] * (1 << (4 * (7 - i)));
            s += m_nibs[i];
          end
          m_rs = rs[15:0]; m_rt = rt[15:0]; m_sum = s[15:0];
          m_valid = 1; m_cnt = 0; done = 1;
        end
      end
      if (!done && out_ready) m_valid = 0;
    end
  endtask

  // Compare process: DUT against model on every cycle after reset
  always @(negedge clk) begin
    if (chk_en) begin
      check("in_ready",  {15'b0, in_ready},  {15'b0, (!m_valid || out_ready)});
      check("out_valid", {15'b0, out_valid}, {15'b0, m_valid});
      check("out_rs",    out_rs,  m_rs);
      check("out_rt",    out_rt,  m_rt);
      check("out_sum",   out_sum, sum_exp(m_sum));
    end
  end

  task automatic step(input bit v, input logic [3:0] n, input bit l, input bit o, input bit r);
    in_valid = v; in_nibble = n; in_last = l; out_ready = o; rst = r;
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic lit(input string tag, input logic [15:0] rs, input logic [15:0] rt,
                     input logic [15:0] s, input bit v);
    check({tag, "_valid"}, {15'b0, out_valid}, {15'b0, v});
    check({tag, "_rs"}, out_rs, rs);
    check({tag, "_rt"}, out_rt, rt);
    check({tag, "_sum"}, out_sum, sum_exp(s));
  endtask

  initial begin
    n_vec = 0; n_err = 0; chk_en = 0;
    m_cnt = 0; m_valid = 0; m_rs = 0; m_rt = 0; m_sum = 0;
    in_valid = 0; in_nibble = 0; in_last = 0; out_ready = 0; rst = 1;

    step(0, 0, 0, 0, 1);
    chk_en = 1;
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0);
    lit("reset", 16'h0000, 16'h0000, 16'h0000, 0);
    check("reset_in_ready", {15'b0, in_ready}, 16'h0001);

    // Nibbles 1..8 with out_ready high
    for (int i = 1; i <= 8; i++) step(1, 4'(i), 0, 1, 0);
    lit("seq", 16'h1234, 16'h5678, 16'h0024, 1);

    // Early terminate F,E,D
    step(1, 4'hF, 0, 1, 0);
    step(1, 4'hE, 0, 1, 0);
    step(1, 4'hD, 1, 1, 0);
    lit("last", 16'hFED0, 16'h0000, 16'h002A, 1);

    // Eight 0xF nibbles; also proves the nibble after in_last lands at k=0
    for (int i = 0; i < 8; i++) step(1, 4'hF, 0, 1, 0);
    lit("allf", 16'hFFFF, 16'hFFFF, 16'h0078, 1);

    // Backpressure: 1..8, hold 3 cycles, then 8..1
    for (int i = 1; i <= 8; i++) step(1, 4'(i), 0, 1, 0);
    for (int h = 0; h < 3; h++) begin
      in_valid = 1; in_nibble = 4'h8; in_last = 0; out_ready = 0;
      #1;
      check("hold_in_ready", {15'b0, in_ready}, 16'h0000);
      step(1, 4'h8, 0, 0, 0);
      lit("hold", 16'h1234, 16'h5678, 16'h0024, 1);
    end
    for (int i = 8; i >= 1; i--) step(1, 4'(i), 0, 1, 0);
    lit("bp2", 16'h8765, 16'h4321, 16'h0024, 1);

    // Reset mid-packet after 5 nibbles
    for (int i = 0; i < 5; i++) step(1, 4'h3, 0, 1, 0);
    step(0, 0, 0, 1, 1);
    lit("midrst", 16'h0000, 16'h0000, 16'h0000, 0);
    for (int i = 0; i < 8; i++) step(1, 4'hA, 0, 1, 0);
    lit("aaaa", 16'hAAAA, 16'hAAAA, 16'h0050, 1);

    // Simultaneous drain and completion with back-to-back one-nibble packets
    step(1, 4'h3, 1, 1, 0);
    lit("one3", 16'h3000, 16'h0000, 16'h0003, 1);
    step(1, 4'h9, 1, 1, 0);
    lit("one9", 16'h9000, 16'h0000, 16'h0009, 1);
    step(1, 4'hC, 1, 1, 0);
    lit("oneC", 16'hC000, 16'h0000, 16'h000C, 1);

    // Randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      step($urandom_range(99, 0) < 75,
           4'($urandom_range(15, 0)),
           $urandom_range(99, 0) < 12,
           $urandom_range(99, 0) < 60,
           $urandom_range(999, 0) < 8);
    end

    step(0, 0, 0, 1, 0);
    @(negedge clk);
    chk_en = 0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/nibble_pack_unit.md
# nibble_pack_unit

Streaming packer that assembles eight 4-bit nibbles into the two 16-bit operand words consumed by the reduction datapath: rs = aaaa_bbbb_cccc_dddd, rt = eeee_ffff_gggg_hhhh. It sits upstream of the reduction stage, so the 16-bit operand-pair format has a producer as well as a consumer. Input uses a valid/ready nibble stream with an optional early-terminate flag. Output uses a single-entry valid/ready buffer holding one packed pair.

## Interface
Parameters:
- none; nibble width is 4, packet length is 8 nibbles, output word width is 16.

Ports:
- clk  input  1  system clock; all state updates on the rising edge
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  in_nibble is valid this cycle
- in_ready  output  1  packer accepts a nibble this cycle
- in_nibble  input  4  next nibble of the current packet
- in_last  input  1  qualifies in_nibble as the final nibble; remaining positions are zero-padded
- out_valid  output  1  out_rs/out_rt hold a completed packet
- out_ready  input  1  downstream takes the packet this cycle
- out_rs  output  16  packed nibbles 0..3
- out_rt  output  16  packed nibbles 4..7
- out_sum  output  16  unsigned sum of the 8 packed nibbles, zero-extended (only with PACK_SUM_EN)

## Operation
- Accept a nibble when in_valid && in_ready.
- Placement by packet index k (0..7), held in a 3-bit counter:
  - k=0..3 go to rs[15:12], [11:8], [7:4], [3:0].
  - k=4..7 go to rt[15:12], [11:8], [7:4], [3:0].
- Assembly registers asm_rs/asm_rt are cleared to 0 at reset and after every packet completes. Unwritten positions are therefore 0.
- A packet completes on acceptance of the nibble at k=7, or on any accepted nibble with in_last=1, whichever comes first.
- On completion:
  - Final assembly contents, including the nibble being accepted, are copied to the output registers.
  - out_valid is set.
  - The counter returns to 0 and the assembly registers are cleared.
- in_last at k=7 is identical to a normal completion. in_last with k=0 yields a one-nibble packet.
- in_ready = ~out_valid | out_ready.
  - The input stalls only while a completed packet is held unaccepted.
  - in_ready must not depend on in_valid.
- out_valid clears on out_ready when no new completion occurs in the same cycle. A simultaneous drain and completion reloads the output and out_valid stays 1.
- Output registers are stable while out_valid && ~out_ready.
- in_valid=0 changes no state except an output drain.

## Timing
- Reset values:
  - in_ready = 1 (combinational from out_valid=0).
  - out_valid = 0, out_rs = 0, out_rt = 0, out_sum = 0.
  - Counter = 0, assembly registers = 0.
- rst asserted mid-packet discards all partial nibbles and any held output. The first nibble accepted after reset is k=0.
- Latency: the completing nibble accepted at edge N drives out_valid=1 and updated outputs after edge N.
- Throughput: 1 nibble/cycle. With out_ready held at 1, one packet is produced every 8 cycles with no bubbles.
- Backpressure: nibbles of the next packet are accepted while the prior packet is held only if in_ready=1.

## Configuration
- PACK_SUM_EN defined:
  - A 7-bit running-sum accumulator adds each accepted nibble and clears on completion.
  - out_sum = {9'b0, final running sum}, covering 0..120.
  - out_sum is loaded together with out_rs/out_rt.
  - Padded zeros contribute 0.
- PACK_SUM_EN undefined:
  - The accumulator is absent.
  - out_sum is tied to 16'h0000.
  - The port remains, so the interface is unchanged.

## Test plan
- Nibbles 1,2,...,8, out_ready=1 -> one cycle after the 8th: out_valid=1, out_rs=16'h1234, out_rt=16'h5678, out_sum=16'h0024 (with PACK_SUM_EN).
- Nibbles F,E,D with in_last on D -> out_rs=16'hFED0, out_rt=16'h0000, out_sum=16'h002A; the next nibble lands at k=0.
- Eight 0xF nibbles -> out_rs=out_rt=16'hFFFF, out_sum=16'h0078.
- Back-to-back packets 0x1..0x8 then 0x8..0x1, with out_ready held low from the first completion for 3 cycles:
  - in_ready=0 during the hold and outputs stay 16'h1234/16'h5678.
  - After the drain, the second packet yields 16'h8765/16'h4321.
- Reset asserted after 5 nibbles, then eight 0xA nibbles -> no packet from the partial; out_rs=out_rt=16'hAAAA, out_sum=16'h0050.
- Simultaneous drain and completion (out_valid=1, out_ready=1, 8th nibble accepted) -> out_valid stays 1 and outputs update to the new packet next cycle.
